// File: rtl/matrix_entry_if.sv
// Bundles the raw operator inputs and the cleaned entry outputs of the matrix entry front end.
// The master side is the switch/button source; the slave side is the front end itself.
interface matrix_entry_if;
    logic       btn;
    logic [1:0] sw_x;
    logic [1:0] sw_y;
    logic       clear;
    logic       enter;
    logic [1:0] X;
    logic [1:0] Y;
    logic       dup;
    logic       full;
    logic [3:0] entry_cnt;

    modport master (
        output btn, sw_x, sw_y, clear,
        input  enter, X, Y, dup, full, entry_cnt
    );

    modport slave (
        input  btn, sw_x, sw_y, clear,
        output enter, X, Y, dup, full, entry_cnt
    );
endinterface

// File: rtl/matrix_entry_frontend.sv
// Synchronizes and debounces a push-button plus X/Y switches into single-cycle entry pulses,
// rejecting coordinates already seen this session and stopping once the session quota is met.
module matrix_entry_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_ENTRIES     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    matrix_entry_if.slave bus
);

    localparam int               DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       CNT_MAX = 4'(MAX_ENTRIES);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESSING  = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } state_e;

    logic             btn_m_q, btn_s_q;
    logic [1:0]       x_m_q, x_s_q;
    logic [1:0]       y_m_q, y_s_q;
    state_e           state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
    logic             press_acc;
    logic             enter_q, enter_d;
    logic             dup_q, dup_d;
    logic [1:0]       x_q, y_q;
    logic [15:0]      seen_q;
    logic [3:0]       cnt_q;
    logic [3:0]       idx;
    logic             full;

    // Two-flop synchronizers on every raw asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m_q <= 1'b0;
            btn_s_q <= 1'b0;
            x_m_q   <= '0;
            x_s_q   <= '0;
            y_m_q   <= '0;
            y_s_q   <= '0;
        end else begin
            btn_m_q <= bus.btn;
            btn_s_q <= btn_m_q;
            x_m_q   <= bus.sw_x;
            x_s_q   <= x_m_q;
            y_m_q   <= bus.sw_y;
            y_s_q   <= y_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign deb_inc = deb_cnt_q + DEB_W'(1);

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (btn_s_q) begin
                    deb_cnt_d = DEB_W'(1);
                    state_d   = (DEBOUNCE_CYCLES == 1) ? PRESSED : PRESSING;
                end
            end
            PRESSING: begin
                if (!btn_s_q) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASED;
                end else begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_MAX) state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (!btn_s_q) begin
                    // A single-sample debounce releases at once, mirroring the press path.
                    if (DEBOUNCE_CYCLES == 1) begin
                        deb_cnt_d = '0;
                        state_d   = RELEASED;
                    end else begin
                        deb_cnt_d = DEB_W'(1);
                        state_d   = RELEASING;
                    end
                end
            end
            RELEASING: begin
                if (btn_s_q) begin
                    deb_cnt_d = '0;
                    state_d   = PRESSED;
                end else if (deb_inc == DEB_MAX) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASED;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
            default: begin
                deb_cnt_d = '0;
                state_d   = RELEASED;
            end
        endcase
    end

    assign idx  = {y_s_q, x_s_q};
    assign full = (cnt_q == CNT_MAX);

    // Acceptance only on entry into PRESSED from the press side; clear and quota both veto it.
    always_comb begin
        press_acc = (state_d == PRESSED) &&
                    ((state_q == PRESSING) || (state_q == RELEASED));
        enter_d   = press_acc && !bus.clear && !full && !seen_q[idx];
        dup_d     = press_acc && !bus.clear && !full &&  seen_q[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_q <= 1'b0;
            dup_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
        end else begin
            enter_q <= enter_d;
            dup_q   <= dup_d;
            if (bus.clear) begin
                seen_q <= '0;
                cnt_q  <= '0;
            end else if (enter_d) begin
                seen_q <= seen_q | (16'd1 << idx);
                cnt_q  <= cnt_q + 4'd1;
                x_q    <= x_s_q;
                y_q    <= y_s_q;
            end
        end
    end

    assign bus.enter     = enter_q;
    assign bus.dup       = dup_q;
    assign bus.X         = x_q;
    assign bus.Y         = y_q;
    assign bus.full      = full;
    assign bus.entry_cnt = cnt_q;

endmodule

// File: tb/tb_matrix_entry_frontend.sv
// Directed bench for the matrix entry front end: reset, debounce timing, bounces,
// duplicates, session quota, clear priority and asynchronous reset mid-debounce.
module tb_matrix_entry_frontend;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   enters   = 0;
    int   dups     = 0;
    int   e0, d0;

    matrix_entry_if bus ();

    matrix_entry_frontend #(
        .DEBOUNCE_CYCLES(4),
        .MAX_ENTRIES    (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [1:0] x, input logic [1:0] y);
        bus.sw_x = x;
        bus.sw_y = y;
        bus.btn  = 1'b1;
        step(10);
        bus.btn  = 1'b0;
        step(10);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
    endtask

    // Pulse counters sampled mid-cycle; enter and dup must never coincide.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.enter) begin
                enters++;
                chk("enter_dup_exclusive", int'(bus.dup), 0);
            end
            if (bus.dup) dups++;
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.btn   = 1'b1;
        bus.sw_x  = 2'd3;
        bus.sw_y  = 2'd3;
        bus.clear = 1'b0;

        // 1: reset with button held, then a full debounce after release
        step(3);
        chk("rst_enter", int'(bus.enter), 0);
        chk("rst_dup",   int'(bus.dup), 0);
        chk("rst_full",  int'(bus.full), 0);
        chk("rst_X",     int'(bus.X), 0);
        chk("rst_Y",     int'(bus.Y), 0);
        chk("rst_cnt",   int'(bus.entry_cnt), 0);
        rst_n = 1'b1;
        e0 = enters;
        step(20);
        chk("t1_enters", enters - e0, 1);
        chk("t1_X",      int'(bus.X), 3);
        chk("t1_Y",      int'(bus.Y), 3);
        chk("t1_cnt",    int'(bus.entry_cnt), 1);
        bus.btn = 1'b0;
        step(10);
        pulse_clear();
        chk("t1_clr_cnt",  int'(bus.entry_cnt), 0);
        chk("t1_clr_full", int'(bus.full), 0);

        // 2: clean press, enter exactly on the sixth edge after btn rises
        bus.sw_x = 2'd2;
        bus.sw_y = 2'd1;
        bus.btn  = 1'b1;
        e0 = enters;
        step(5);
        chk("t2_early",   int'(bus.enter), 0);
        step(1);
        chk("t2_enter",   int'(bus.enter), 1);
        chk("t2_X",       int'(bus.X), 2);
        chk("t2_Y",       int'(bus.Y), 1);
        chk("t2_cnt",     int'(bus.entry_cnt), 1);
        chk("t2_dup",     int'(bus.dup), 0);
        step(1);
        chk("t2_onecyc",  int'(bus.enter), 0);
        step(13);
        chk("t2_enters",  enters - e0, 1);
        bus.btn = 1'b0;
        step(10);

        // 3: short bounce then a real press; timing runs from the second rise
        bus.sw_x = 2'd0;
        bus.sw_y = 2'd0;
        e0 = enters;
        bus.btn = 1'b1; step(3);
        bus.btn = 1'b0; step(1);
        bus.btn = 1'b1;
        step(5);
        chk("t3_early",   int'(bus.enter), 0);
        step(1);
        chk("t3_enter",   int'(bus.enter), 1);
        step(8);
        bus.btn = 1'b0; step(2);
        bus.btn = 1'b1; step(2);
        bus.btn = 1'b0; step(10);
        chk("t3_enters",  enters - e0, 1);
        chk("t3_cnt",     int'(bus.entry_cnt), 2);

        // 4: duplicate of (2,1)
        bus.sw_x = 2'd2;
        bus.sw_y = 2'd1;
        bus.btn  = 1'b1;
        e0 = enters;
        d0 = dups;
        step(5);
        chk("t4_early",   int'(bus.dup), 0);
        step(1);
        chk("t4_dup",     int'(bus.dup), 1);
        chk("t4_noenter", int'(bus.enter), 0);
        step(1);
        chk("t4_onecyc",  int'(bus.dup), 0);
        bus.btn = 1'b0;
        step(10);
        chk("t4_dups",    dups - d0, 1);
        chk("t4_enters",  enters - e0, 0);
        chk("t4_cnt",     int'(bus.entry_cnt), 2);
        chk("t4_X",       int'(bus.X), 0);
        chk("t4_Y",       int'(bus.Y), 0);

        // 5: quota, saturation, then clear reopens the session
        press(2'd1, 2'd0);
        press(2'd3, 2'd2);
        press(2'd0, 2'd3);
        chk("t5_cnt5",    int'(bus.entry_cnt), 5);
        chk("t5_full",    int'(bus.full), 1);
        e0 = enters;
        d0 = dups;
        press(2'd3, 2'd3);
        chk("t5_sat_enters", enters - e0, 0);
        chk("t5_sat_dups",   dups - d0, 0);
        chk("t5_sat_cnt",    int'(bus.entry_cnt), 5);
        pulse_clear();
        chk("t5_clr_full",   int'(bus.full), 0);
        chk("t5_clr_cnt",    int'(bus.entry_cnt), 0);
        e0 = enters;
        d0 = dups;
        press(2'd2, 2'd1);
        chk("t5_re_enters",  enters - e0, 1);
        chk("t5_re_dups",    dups - d0, 0);
        chk("t5_re_cnt",     int'(bus.entry_cnt), 1);
        chk("t5_re_X",       int'(bus.X), 2);
        chk("t5_re_Y",       int'(bus.Y), 1);

        // 6a: clear on the acceptance edge drops the press
        bus.sw_x = 2'd1;
        bus.sw_y = 2'd1;
        bus.btn  = 1'b1;
        e0 = enters;
        d0 = dups;
        step(5);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        chk("t6_clr_enter", int'(bus.enter), 0);
        chk("t6_clr_dup",   int'(bus.dup), 0);
        chk("t6_clr_cnt",   int'(bus.entry_cnt), 0);
        bus.btn = 1'b0;
        step(10);
        chk("t6_clr_enters", enters - e0, 0);
        chk("t6_clr_dups",   dups - d0, 0);
        e0 = enters;
        press(2'd1, 2'd1);
        chk("t6_after_enters", enters - e0, 1);
        chk("t6_after_X",      int'(bus.X), 1);

        // 6b: asynchronous reset mid-PRESSING, held button must re-debounce
        bus.sw_x = 2'd3;
        bus.sw_y = 2'd0;
        bus.btn  = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt",   int'(bus.entry_cnt), 0);
        chk("t6_rst_X",     int'(bus.X), 0);
        chk("t6_rst_Y",     int'(bus.Y), 0);
        chk("t6_rst_enter", int'(bus.enter), 0);
        chk("t6_rst_full",  int'(bus.full), 0);
        step(2);
        rst_n = 1'b1;
        e0 = enters;
        step(5);
        chk("t6_rst_early",  int'(bus.enter), 0);
        chk("t6_rst_none",   enters - e0, 0);
        step(1);
        chk("t6_rst_enter2", int'(bus.enter), 1);
        chk("t6_rst_X2",     int'(bus.X), 3);
        chk("t6_rst_Y2",     int'(bus.Y), 0);
        chk("t6_rst_cnt2",   int'(bus.entry_cnt), 1);
        bus.btn = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
